// File: rtl/tc_pkg.sv
// Shared tensorcore package: element typedefs, tile geometry and the
// row-major tile flatten helper used by everything that walks a tile.
package tc_pkg;

    typedef logic [15:0] fp16_t;
    typedef logic [7:0]  fp8_t;

    localparam int TC_M = 4;
    localparam int TC_N = 4;
    localparam int TC_K = 8;

    // Element [r][c] of a flattened tile lives at element slot r*TC_N+c
    function automatic int idx(input int r, input int c);
        return r * TC_N + c;
    endfunction

endpackage

// File: rtl/tc_tile_fifo.sv
// Register FIFO holding whole result tiles. The caller qualifies push and
// pop (no push when full unless popping, no pop when empty); pointers wrap
// modulo DEPTH and the occupancy is an explicit counter.
module tc_tile_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [WIDTH-1:0]         head_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [PW-1:0]    rdPtr_q, rdPtr_d;
    logic [CW-1:0]    count_q, count_d;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rdPtr_q];

    // Advance pointers and occupancy; a simultaneous push and pop keeps the count
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (push_i) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (pop_i) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and counter registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Tile storage needs no reset; contents are only read when counted valid
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

endmodule

// File: rtl/tc_result_drain.sv
// Tensorcore result drain: captures each result tile on tc_valid into a
// tile FIFO and streams it out one row per beat on a valid/ready port.
// Optional feature macro TC_DRAIN_CHECKSUM_EN: when defined, checksum holds
// the XOR of all elements of the last accepted tile; otherwise it is 0.
module tc_result_drain
    import tc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ROWS  = TC_M,
    parameter int COLS  = TC_N,
    parameter int W     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tc_valid,
    input  logic [ROWS*COLS*W-1:0]    tc_d,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [COLS*W-1:0]         m_data,
    output logic                      m_last,
    output logic [$clog2(DEPTH):0]    occupancy,
    output logic                      overflow,
    output logic [W-1:0]              checksum
);

    localparam int TILE_W = ROWS * COLS * W;
    localparam int ROW_W  = COLS * W;
    localparam int RCW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [RCW-1:0] LAST_ROW = RCW'(ROWS - 1);

    logic                   fifoFull;
    logic                   fifoEmpty;
    logic [TILE_W-1:0]      headTile;
    logic [RCW-1:0]         rowCnt_q, rowCnt_d;
    logic                   overflow_q, overflow_d;
    logic                   beatFire;
    logic                   popFire;
    logic                   pushOk;

    // A full FIFO still takes a tile when its head is leaving this same edge
    assign m_valid  = !fifoEmpty;
    assign beatFire = m_valid && m_ready;
    assign popFire  = beatFire && (rowCnt_q == LAST_ROW);
    assign pushOk   = tc_valid && (!fifoFull || popFire);
    assign m_data   = headTile[ROW_W*int'(rowCnt_q) +: ROW_W];
    assign m_last   = (rowCnt_q == LAST_ROW);
    assign overflow = overflow_q;

    tc_tile_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TILE_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (pushOk),
        .pop_i   (popFire),
        .data_i  (tc_d),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (occupancy),
        .head_o  (headTile)
    );

    // Row counter steps on each beat and returns to 0 as the tile pops; overflow is sticky
    always_comb begin
        rowCnt_d   = rowCnt_q;
        overflow_d = overflow_q;
        if (beatFire) begin
            rowCnt_d = popFire ? '0 : rowCnt_q + 1'b1;
        end
        if (tc_valid && !pushOk) begin
            overflow_d = 1'b1;
        end
    end

    // Row counter and overflow flag registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            rowCnt_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            rowCnt_q   <= rowCnt_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef TC_DRAIN_CHECKSUM_EN
    logic [W-1:0] checksum_q, checksum_d;
    logic [W-1:0] tileXor;

    // XOR reduction over every element of the incoming tile
    always_comb begin
        tileXor = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                tileXor = tileXor ^ tc_d[(r*COLS + c)*W +: W];
            end
        end
        checksum_d = pushOk ? tileXor : checksum_q;
    end

    // Checksum only follows tiles that were actually accepted
    always_ff @(posedge clk) begin
        if (!rst) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_tc_result_drain.sv
// Self-checking bench for tc_result_drain: a table of single-tile vectors
// followed by hand-written backpressure, overflow, full-with-pop and
// mid-stream reset sequences. Expected row beats go into a scoreboard queue.
// Honours TC_DRAIN_CHECKSUM_EN the same way the design does.
module tb_tc_result_drain;
    import tc_pkg::*;

    localparam int DEPTH = 4;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int W     = 16;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   tc_valid = 1'b0;
    logic [ROWS*COLS*W-1:0] tc_d = '0;
    logic                   m_valid;
    logic                   m_ready = 1'b0;
    logic [COLS*W-1:0]      m_data;
    logic                   m_last;
    logic [$clog2(DEPTH):0] occupancy;
    logic                   overflow;
    logic [W-1:0]           checksum;

    typedef struct {
        logic [63:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        logic [255:0] tile;
        logic [63:0]  expRow0;
        logic [15:0]  expXor;
    } vec_t;

    beat_t expQ[$];
    beat_t monBeat;
    vec_t  vecs[4];
    int    total = 0;
    int    bad   = 0;

    tc_result_drain #(
        .DEPTH (DEPTH),
        .ROWS  (ROWS),
        .COLS  (COLS),
        .W     (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tc_valid  (tc_valid),
        .tc_d      (tc_d),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .occupancy (occupancy),
        .overflow  (overflow),
        .checksum  (checksum)
    );

    // Free-running core clock
    always #5 clk = ~clk;

    // Hard stop in case something wedges
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [255:0] makeTile(input int seed);
        logic [255:0] t;
        t = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                t[idx(r, c)*W +: W] = 16'(seed*256 + r*16 + c);
        return t;
    endfunction

    function automatic logic [63:0] rowOf(input logic [255:0] t, input int r);
        return t[r*64 +: 64];
    endfunction

    function automatic logic [15:0] xorTile(input logic [255:0] t);
        logic [15:0] x;
        x = '0;
        for (int i = 0; i < ROWS*COLS; i++) x = x ^ t[i*W +: W];
        return x;
    endfunction

    function automatic logic [15:0] expChecksum(input logic [15:0] x);
`ifdef TC_DRAIN_CHECKSUM_EN
        return x;
`else
        return 16'h0000 & x;
`endif
    endfunction

    // Present one tile for one cycle; accepted tiles add their rows to the scoreboard
    task automatic applyStimulus(input logic [255:0] tile, input bit accept);
        beat_t b;
        @(posedge clk);
        #1;
        tc_valid = 1'b1;
        tc_d     = tile;
        if (accept) begin
            for (int r = 0; r < ROWS; r++) begin
                b.data = rowOf(tile, r);
                b.last = (r == ROWS-1);
                expQ.push_back(b);
            end
        end
        @(posedge clk);
        #1;
        tc_valid = 1'b0;
    endtask

    // Wait until every expected beat has been seen and the port is idle
    task automatic waitDrain(input int bound);
        int n;
        n = 0;
        while (!(expQ.size() == 0 && !m_valid) && n < bound) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= bound) begin
            bad++;
            $display("[TB] FAIL drain: %0d beats still pending, m_valid=%0b after %0d cycles", expQ.size(), m_valid, bound);
        end
    endtask

    // Scoreboard monitor: a beat fires at the next rising edge when valid and ready
    always @(negedge clk) begin
        if (rst && m_valid && m_ready) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected beat: got data %h last %0b, required no beat", m_data, m_last);
            end else begin
                monBeat = expQ.pop_front();
                checkOutput("beat data", m_data, monBeat.data);
                checkOutput("beat last", m_last, monBeat.last);
            end
        end
    end

    initial begin
        logic [255:0] t;

        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                vecs[0].tile[idx(r, c)*W +: W] = 16'(256*r + c);
                vecs[1].tile[idx(r, c)*W +: W] = 16'h3C00;
                vecs[2].tile[idx(r, c)*W +: W] = 16'h0000;
                vecs[3].tile[idx(r, c)*W +: W] = 16'hFFFF;
            end
        vecs[1].tile[idx(3, 3)*W +: W] = 16'h0001;
        vecs[2].tile[idx(0, 1)*W +: W] = 16'hABCD;
        vecs[0].expRow0 = 64'h0003_0002_0001_0000;
        vecs[1].expRow0 = 64'h3C00_3C00_3C00_3C00;
        vecs[2].expRow0 = 64'h0000_0000_ABCD_0000;
        vecs[3].expRow0 = 64'hFFFF_FFFF_FFFF_FFFF;
        vecs[0].expXor  = 16'h0000;
        vecs[1].expXor  = 16'h3C01;
        vecs[2].expXor  = 16'hABCD;
        vecs[3].expXor  = 16'h0000;

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset m_valid", m_valid, 0);
        checkOutput("reset occupancy", occupancy, 0);
        checkOutput("reset overflow", overflow, 0);
        checkOutput("reset checksum", checksum, 0);
        @(posedge clk);
        #1;
        rst     = 1'b1;
        m_ready = 1'b1;

        // Table: one tile each, streamed with m_ready held high
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i].tile, 1'b1);
            @(negedge clk);
            checkOutput("vec row0", m_data, vecs[i].expRow0);
            checkOutput("vec occupancy", occupancy, 1);
            checkOutput("vec checksum", checksum, expChecksum(vecs[i].expXor));
            for (int k = 0; k < ROWS; k++) begin
                if (k > 0) @(negedge clk);
                checkOutput("vec consecutive valid", m_valid, 1);
            end
            @(negedge clk);
            checkOutput("vec idle valid", m_valid, 0);
            checkOutput("vec idle occupancy", occupancy, 0);
        end

        // Backpressure after beat1 for five cycles
        t = makeTile(10);
        applyStimulus(t, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checkOutput("hold valid", m_valid, 1);
            checkOutput("hold data", m_data, rowOf(t, 2));
            checkOutput("hold last", m_last, 0);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("bp occupancy before last", occupancy, 1);
        checkOutput("bp last flag", m_last, 1);
        @(negedge clk);
        checkOutput("bp occupancy after last", occupancy, 0);
        waitDrain(20);

        // Overflow: five tiles into a four-deep FIFO with the port stalled
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        for (int s = 0; s < 5; s++) applyStimulus(makeTile(20 + s), s < 4);
        @(negedge clk);
        checkOutput("ovf occupancy", occupancy, 4);
        checkOutput("ovf flag", overflow, 1);
        checkOutput("ovf checksum", checksum, expChecksum(xorTile(makeTile(23))));
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        waitDrain(100);
        checkOutput("ovf sticky", overflow, 1);

        // Full FIFO: push lands on the same edge as the head's final row
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst2 overflow", overflow, 0);
        checkOutput("rst2 occupancy", occupancy, 0);
        checkOutput("rst2 m_valid", m_valid, 0);
        for (int s = 0; s < 4; s++) applyStimulus(makeTile(30 + s), 1'b1);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        applyStimulus(makeTile(40), 1'b1);
        @(negedge clk);
        checkOutput("full pushpop occupancy", occupancy, 4);
        checkOutput("full pushpop overflow", overflow, 0);
        waitDrain(100);
        checkOutput("full pushpop overflow end", overflow, 0);

        // Reset after beat1 of the first of two queued tiles
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        applyStimulus(makeTile(50), 1'b1);
        applyStimulus(makeTile(51), 1'b1);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        expQ.delete();
        @(negedge clk);
        checkOutput("midrst m_valid", m_valid, 0);
        checkOutput("midrst occupancy", occupancy, 0);
        checkOutput("midrst overflow", overflow, 0);
        t = makeTile(52);
        applyStimulus(t, 1'b1);
        @(negedge clk);
        checkOutput("midrst fresh row0", m_data, rowOf(t, 0));
        waitDrain(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
